// File: rtl/fighter_action_scheduler_if.sv
// Handshake bundle between a fighter's input decode, its punch/kick motion
// controllers and the action scheduler.
interface fighter_action_scheduler_if;
    localparam int unsigned MOTION_W = 32;
    localparam int unsigned ACTION_W = 3;

    logic                       frame_tick;
    logic                       Punch;
    logic                       Kick;
    logic                       Walk_L;
    logic                       Walk_R;
    logic                       Hit;
    logic signed [MOTION_W-1:0] Punch_Motion;
    logic signed [MOTION_W-1:0] Kick_Motion;
    logic                       Punch_Done;
    logic                       Kick_Done;
    logic                       Punch_Go;
    logic                       Kick_Go;
    logic signed [MOTION_W-1:0] X_Motion;
    logic [ACTION_W-1:0]        Action;
    logic                       Busy;

    modport master (
        output frame_tick, Punch, Kick, Walk_L, Walk_R, Hit,
               Punch_Motion, Kick_Motion, Punch_Done, Kick_Done,
        input  Punch_Go, Kick_Go, X_Motion, Action, Busy
    );

    modport slave (
        input  frame_tick, Punch, Kick, Walk_L, Walk_R, Hit,
               Punch_Motion, Kick_Motion, Punch_Done, Kick_Done,
        output Punch_Go, Kick_Go, X_Motion, Action, Busy
    );
endinterface

// File: rtl/fighter_action_scheduler.sv
// Per-frame fighter action FSM: picks idle/walk, punch, kick, recovery or
// hit-stun, launches motion controllers and muxes their X motion.
module fighter_action_scheduler #(
    parameter int WALK_SPEED        = 2,
    parameter int RECOVER_FRAMES    = 4,
    parameter int STUN_FRAMES       = 12,
    parameter int KNOCKBACK         = -3,
    parameter int MAX_ACTION_FRAMES = 16
) (
    input  logic                       clk,
    input  logic                       Reset,
    fighter_action_scheduler_if.slave  bus
);
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned MOTION_W = 32;

    localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] S_PUNCH   = 3'd1;
    localparam logic [STATE_W-1:0] S_KICK    = 3'd2;
    localparam logic [STATE_W-1:0] S_RECOVER = 3'd3;
    localparam logic [STATE_W-1:0] S_STUN    = 3'd4;

    localparam logic signed [1:0] DIR_0 = 2'sb00;
    localparam logic signed [1:0] DIR_R = 2'sb01;
    localparam logic signed [1:0] DIR_L = 2'sb11;

    localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(MAX_ACTION_FRAMES - 1);
    localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(RECOVER_FRAMES - 1);
    localparam logic [CNT_W-1:0] STUN_LAST = CNT_W'(STUN_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [STATE_W-1:0] state, state_d;
    logic [CNT_W-1:0]   frame_cnt, frame_cnt_d;
    logic               hit_pending, hit_pending_d;
    logic signed [1:0]  walk_dir, walk_dir_d;
    logic               punch_go, punch_go_d;
    logic               kick_go, kick_go_d;
    logic               hit_now;

    // A hit in the tick cycle itself counts toward that tick.
    assign hit_now = hit_pending | bus.Hit;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state       <= S_IDLE;
            frame_cnt   <= '0;
            hit_pending <= 1'b0;
            walk_dir    <= DIR_0;
            punch_go    <= 1'b0;
            kick_go     <= 1'b0;
        end else begin
            state       <= state_d;
            frame_cnt   <= frame_cnt_d;
            hit_pending <= hit_pending_d;
            walk_dir    <= walk_dir_d;
            punch_go    <= punch_go_d;
            kick_go     <= kick_go_d;
        end
    end

    always_comb begin
        state_d       = state;
        frame_cnt_d   = frame_cnt;
        hit_pending_d = hit_pending | bus.Hit;
        walk_dir_d    = walk_dir;
        punch_go_d    = 1'b0;
        kick_go_d     = 1'b0;

        if (bus.frame_tick) begin
            // The tick consumes any pending hit; only a fresh hit landing on
            // top of an already-pending one survives to the next tick.
            hit_pending_d = hit_pending & bus.Hit;

            if (hit_now) begin
                state_d = S_STUN;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.Punch) begin
                            state_d    = S_PUNCH;
                            punch_go_d = 1'b1;
                        end else if (bus.Kick) begin
                            state_d   = S_KICK;
                            kick_go_d = 1'b1;
                        end else if (bus.Walk_R && !bus.Walk_L) begin
                            walk_dir_d = DIR_R;
                        end else if (bus.Walk_L && !bus.Walk_R) begin
                            walk_dir_d = DIR_L;
                        end else begin
                            walk_dir_d = DIR_0;
                        end
                    end
                    S_PUNCH: begin
                        if ((frame_cnt != '0 && bus.Punch_Done) || frame_cnt >= ACT_LAST)
                            state_d = S_RECOVER;
                    end
                    S_KICK: begin
                        if ((frame_cnt != '0 && bus.Kick_Done) || frame_cnt >= ACT_LAST)
                            state_d = S_RECOVER;
                    end
                    S_RECOVER: begin
                        if (frame_cnt >= REC_LAST)
                            state_d = S_IDLE;
                    end
                    S_STUN: begin
                        if (frame_cnt >= STUN_LAST)
                            state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            // Every entry (including a stun re-entry) restarts the frame count.
            if (hit_now || state_d != state) begin
                frame_cnt_d = '0;
                if (state_d != S_IDLE)
                    walk_dir_d = DIR_0;
            end else if (frame_cnt != CNT_MAX) begin
                frame_cnt_d = frame_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.X_Motion = '0;
        case (state)
            S_IDLE: begin
                if (walk_dir == DIR_R)
                    bus.X_Motion = MOTION_W'(WALK_SPEED);
                else if (walk_dir == DIR_L)
                    bus.X_Motion = MOTION_W'(-WALK_SPEED);
                else
                    bus.X_Motion = '0;
            end
            S_PUNCH: bus.X_Motion = bus.Punch_Motion;
            S_KICK:  bus.X_Motion = bus.Kick_Motion;
            S_STUN:  bus.X_Motion = MOTION_W'(KNOCKBACK);
            default: bus.X_Motion = '0;
        endcase
    end

    assign bus.Punch_Go = punch_go;
    assign bus.Kick_Go  = kick_go;
    assign bus.Action   = state;
    assign bus.Busy     = (state != S_IDLE);

endmodule

// File: tb/tb_fighter_action_scheduler.sv
// Self-checking bench for fighter_action_scheduler: table of per-tick vectors
// plus hand sequences for hit-stun, watchdog and reset corners.
module tb_fighter_action_scheduler;
    logic clk = 1'b0;
    logic Reset;

    always #5 clk = ~clk;

    fighter_action_scheduler_if bus ();

    fighter_action_scheduler dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        int action;
        int x;
        bit pgo;
        bit kgo;
    } exp_t;

    typedef struct {
        bit p, k, wl, wr, pd, kd;
        int pm, km;
        int ea, ex;
        bit epg, ekg;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(bit p, bit k, bit wl, bit wr, bit pd, bit kd,
                                int pm, int km, int ea, int ex, bit epg, bit ekg);
        vec_t v;
        v.p = p; v.k = k; v.wl = wl; v.wr = wr; v.pd = pd; v.kd = kd;
        v.pm = pm; v.km = km; v.ea = ea; v.ex = ex; v.epg = epg; v.ekg = ekg;
        return v;
    endfunction

    function automatic exp_t ex_of(int a, int x, bit pg, bit kg);
        exp_t e;
        e.action = a; e.x = x; e.pgo = pg; e.kgo = kg;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".action"}, int'(bus.Action), e.action);
        chk({tag, ".x"}, int'(bus.X_Motion), e.x);
        chk({tag, ".punch_go"}, int'(bus.Punch_Go), int'(e.pgo));
        chk({tag, ".kick_go"}, int'(bus.Kick_Go), int'(e.kgo));
        chk({tag, ".busy"}, int'(bus.Busy), (e.action != 0) ? 1 : 0);
    endtask

    // One frame tick followed by a quiet clk; Go must be gone on the quiet clk.
    task automatic do_tick(input string tag, input exp_t e);
        exp_t got;
        exp_t quiet;
        sb.push_back(e);
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        got = sb.pop_front();
        chk_outputs(tag, got);
        quiet = got;
        quiet.pgo = 1'b0;
        quiet.kgo = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs({tag, ".quiet"}, quiet);
    endtask

    task automatic hit_pulse();
        bus.Hit = 1'b1;
        @(posedge clk);
        #1;
        bus.Hit = 1'b0;
    endtask

    initial begin
        Reset            = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.Punch        = 1'b0;
        bus.Kick         = 1'b0;
        bus.Walk_L       = 1'b0;
        bus.Walk_R       = 1'b0;
        bus.Hit          = 1'b0;
        bus.Punch_Motion = '0;
        bus.Kick_Motion  = '0;
        bus.Punch_Done   = 1'b1;
        bus.Kick_Done    = 1'b1;

        // p k wl wr pd kd pm km -> action x pgo kgo
        tbl.push_back(mk(0,0,0,1,1,1, 0, 0, 0, 2,0,0));
        tbl.push_back(mk(0,0,1,0,1,1, 0, 0, 0,-2,0,0));
        tbl.push_back(mk(0,0,1,1,1,1, 0, 0, 0, 0,0,0));
        tbl.push_back(mk(0,0,0,1,1,1, 0, 0, 0, 2,0,0));
        tbl.push_back(mk(1,0,0,1,1,1, 9, 0, 1, 9,1,0));
        tbl.push_back(mk(0,0,0,0,0,1, 8, 0, 1, 8,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 7, 0, 1, 7,0,0));
        tbl.push_back(mk(0,0,0,0,1,1, 7, 0, 3, 0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,0,0,0,1,1, 0, 0, 3, 0,0,0));
        tbl.push_back(mk(1,0,0,0,1,1, 0, 0, 0, 0,0,0));
        tbl.push_back(mk(1,0,0,0,1,1, 5, 0, 1, 5,1,0));
        tbl.push_back(mk(0,0,0,0,1,1, 4, 0, 1, 4,0,0));
        tbl.push_back(mk(0,0,0,0,1,1, 4, 0, 3, 0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,0,0,0,1,1, 0, 0, 3, 0,0,0));
        tbl.push_back(mk(0,0,0,0,1,1, 0, 0, 0, 0,0,0));
        tbl.push_back(mk(1,1,0,0,1,1, 6, 0, 1, 6,1,0));
        tbl.push_back(mk(0,0,0,0,1,1, 6, 0, 1, 6,0,0));
        tbl.push_back(mk(0,0,0,0,1,1, 6, 0, 3, 0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,0,0,0,1,1, 0, 0, 3, 0,0,0));
        tbl.push_back(mk(0,0,0,0,1,1, 0, 0, 0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,1,0, 0,-5, 2,-5,0,1));
        tbl.push_back(mk(0,0,0,0,1,0, 0,-4, 2,-4,0,0));
        tbl.push_back(mk(0,0,0,0,1,1, 0,-4, 3, 0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,0,0,0,1,1, 0, 0, 3, 0,0,0));
        tbl.push_back(mk(0,0,0,0,1,1, 0, 0, 0, 0,0,0));

        #1;
        chk_outputs("reset", ex_of(0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            bus.Punch        = tbl[i].p;
            bus.Kick         = tbl[i].k;
            bus.Walk_L       = tbl[i].wl;
            bus.Walk_R       = tbl[i].wr;
            bus.Punch_Done   = tbl[i].pd;
            bus.Kick_Done    = tbl[i].kd;
            bus.Punch_Motion = tbl[i].pm;
            bus.Kick_Motion  = tbl[i].km;
            do_tick($sformatf("vec%0d", i),
                    ex_of(tbl[i].ea, tbl[i].ex, tbl[i].epg, tbl[i].ekg));
        end
        bus.Punch = 1'b0; bus.Kick = 1'b0; bus.Walk_L = 1'b0; bus.Walk_R = 1'b0;

        // Hit between ticks during KICK, then a re-hit restarting the stun.
        bus.Kick = 1'b1; bus.Kick_Done = 1'b0; bus.Kick_Motion = 3;
        do_tick("kick_enter", ex_of(2, 3, 0, 1));
        bus.Kick = 1'b0;
        do_tick("kick_hold", ex_of(2, 3, 0, 0));
        hit_pulse();
        chk_outputs("hit_deferred", ex_of(2, 3, 0, 0));
        do_tick("stun_enter", ex_of(4, -3, 0, 0));
        for (int i = 1; i <= 5; i++)
            do_tick($sformatf("stun_a%0d", i), ex_of(4, -3, 0, 0));
        hit_pulse();
        do_tick("stun_reenter", ex_of(4, -3, 0, 0));
        for (int i = 1; i <= 11; i++)
            do_tick($sformatf("stun_b%0d", i), ex_of(4, -3, 0, 0));
        do_tick("stun_exit", ex_of(0, 0, 0, 0));
        bus.Kick_Done = 1'b1;

        // Watchdog: controller never reports done.
        bus.Punch = 1'b1; bus.Punch_Done = 1'b0; bus.Punch_Motion = 1;
        do_tick("wd_enter", ex_of(1, 1, 1, 0));
        bus.Punch = 1'b0;
        for (int i = 1; i <= 15; i++)
            do_tick($sformatf("wd_hold%0d", i), ex_of(1, 1, 0, 0));
        do_tick("wd_fire", ex_of(3, 0, 0, 0));
        bus.Punch_Done = 1'b1;
        for (int i = 1; i <= 3; i++)
            do_tick($sformatf("wd_rec%0d", i), ex_of(3, 0, 0, 0));
        do_tick("wd_idle", ex_of(0, 0, 0, 0));

        // Reset mid-PUNCH takes effect without a clock edge.
        bus.Punch = 1'b1; bus.Punch_Motion = 7;
        do_tick("rst_punch", ex_of(1, 7, 1, 0));
        bus.Punch = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        chk_outputs("rst_async", ex_of(0, 0, 0, 0));
        @(posedge clk);
        #1;
        Reset = 1'b1;
        for (int i = 1; i <= 3; i++)
            do_tick($sformatf("rst_idle%0d", i), ex_of(0, 0, 0, 0));

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end
endmodule
